piece_phase_fsm: RTL and testbench

- Parametrised successor to the in-game lock FSM.
- Sequences the full per-piece lifecycle: spawn, fall, lock delay, line-clear delay, entry delay (ARE), top-out.
- Adds a bounded move-reset lock delay with an optional step-reset mode, and configurable delays.
- Sits between the input/movement logic and the playfield/queue logic; drives spawn and lock strobes to both.

---
 rtl/piece_phase_fsm_pkg.sv | 29 ++
 rtl/piece_phase_fsm_counter.sv | 28 ++
 rtl/piece_phase_fsm_ground_detect.sv | 39 +++
 rtl/piece_phase_fsm.sv | 181 ++++++++++++++++++
 tb/tb_piece_phase_fsm.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/piece_phase_fsm_pkg.sv
// Shared state encoding, default timing constants and width helper for the
// per-piece lifecycle sequencer.
package piece_phase_fsm_pkg;

  typedef enum logic [2:0] {
    PH_IDLE      = 3'd0,
    PH_SPAWN     = 3'd1,
    PH_FALLING   = 3'd2,
    PH_LOCK      = 3'd3,
    PH_CLEAR     = 3'd4,
    PH_ENTRY     = 3'd5,
    PH_GAME_OVER = 3'd6
  } phase_states_t;

  localparam int LOCK_DELAY_DFLT      = 15;
  localparam int CLEAR_DELAY_DFLT     = 20;
  localparam int ARE_DELAY_DFLT       = 10;
  localparam int MAX_LOCK_RESETS_DFLT = 15;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_w(input int max_val);
    if (max_val < 2) begin
      return 1;
    end else begin
      return $clog2(max_val + 1);
    end
  endfunction

endpackage

// File: rtl/piece_phase_fsm_counter.sv
// Generic loadable up/down counter; load has priority over count enable.
module piece_phase_fsm_counter #(
  parameter int unsigned W       = 4,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_l,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         up,
  output logic [W-1:0] count
);

  // Count register
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      count <= RST_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= up ? (count + W'(1)) : (count - W'(1));
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/piece_phase_fsm_ground_detect.sv
// Falling piece is grounded when every one of its cells coincides with a ghost
// cell; also reports the deepest (largest) row the falling piece occupies.
module piece_phase_fsm_ground_detect #(
  parameter int N_CELLS = 4,
  parameter int COORD_W = 5
) (
  input  logic [N_CELLS-1:0][COORD_W-1:0] ftr_rows,
  input  logic [N_CELLS-1:0][COORD_W-1:0] ftr_cols,
  input  logic [N_CELLS-1:0][COORD_W-1:0] ghost_rows,
  input  logic [N_CELLS-1:0][COORD_W-1:0] ghost_cols,
  output logic                            grounded,
  output logic [COORD_W-1:0]              max_row
);

  logic [N_CELLS-1:0] cell_hit_s;

  // All-pairs cell match and row maximum
  always_comb begin
    cell_hit_s = '0;
    max_row    = '0;
    for (int i = 0; i < N_CELLS; i++) begin
      for (int j = 0; j < N_CELLS; j++) begin
        if ((ftr_rows[i] == ghost_rows[j]) && (ftr_cols[i] == ghost_cols[j])) begin
          cell_hit_s[i] = 1'b1;
        end else begin
          cell_hit_s[i] = cell_hit_s[i];
        end
      end
      if (ftr_rows[i] > max_row) begin
        max_row = ftr_rows[i];
      end else begin
        max_row = max_row;
      end
    end
  end

  assign grounded = &cell_hit_s;

endmodule

// File: rtl/piece_phase_fsm.sv
// Per-piece lifecycle sequencer: spawn, fall with bounded move-reset lock
// delay, lock, line-clear delay, entry delay and top-out.
module piece_phase_fsm
  import piece_phase_fsm_pkg::*;
#(
  parameter int N_CELLS         = 4,
  parameter int COORD_W         = 5,
  parameter int LOCK_DELAY      = LOCK_DELAY_DFLT,
  parameter int MAX_LOCK_RESETS = MAX_LOCK_RESETS_DFLT,
  parameter int STEP_RESET      = 1,
  parameter int CLEAR_DELAY     = CLEAR_DELAY_DFLT,
  parameter int ARE_DELAY       = ARE_DELAY_DFLT
) (
  input  logic                                    clk,
  input  logic                                    rst_l,
  input  logic                                    game_start,
  input  logic                                    game_end,
  input  logic                                    user_input,
  input  logic                                    hard_drop,
  input  logic                                    spawn_blocked,
  input  logic [2:0]                              lines_cleared,
  input  logic [N_CELLS-1:0][COORD_W-1:0]         ftr_rows,
  input  logic [N_CELLS-1:0][COORD_W-1:0]         ftr_cols,
  input  logic [N_CELLS-1:0][COORD_W-1:0]         ghost_rows,
  input  logic [N_CELLS-1:0][COORD_W-1:0]         ghost_cols,
  output logic                                    new_tetromino,
  output logic                                    piece_active,
  output logic                                    piece_locked,
  output logic                                    clear_busy,
  output logic                                    game_over,
  output logic [$clog2(MAX_LOCK_RESETS+1)-1:0]    resets_left
);

  localparam int LT_W   = cnt_w(LOCK_DELAY);
  localparam int PT_MAX = (CLEAR_DELAY > ARE_DELAY) ? CLEAR_DELAY : ARE_DELAY;
  localparam int PT_W   = cnt_w(PT_MAX);
  localparam int RL_W   = $clog2(MAX_LOCK_RESETS + 1);

  localparam logic [LT_W-1:0] LT_FULL  = LT_W'(LOCK_DELAY);
  localparam logic [PT_W-1:0] PT_CLEAR = PT_W'(CLEAR_DELAY - 1);
  localparam logic [PT_W-1:0] PT_ARE   = PT_W'((ARE_DELAY > 0) ? (ARE_DELAY - 1) : 0);
  localparam logic [RL_W-1:0] RL_FULL  = RL_W'(MAX_LOCK_RESETS);
  localparam logic [RL_W-1:0] RL_AFTER = RL_W'((MAX_LOCK_RESETS > 0) ? (MAX_LOCK_RESETS - 1) : 0);

  phase_states_t       state_r, state_nxt_s;
  logic [COORD_W-1:0]  deepest_row_r, max_row_s;
  logic                grounded_s, step_s, reload_ok_s, lock_now_s, reload_s, deep_load_s;
  logic [LT_W-1:0]     lock_timer_s;
  logic                lt_load_s, lt_en_s;
  logic [PT_W-1:0]     phase_timer_s, pt_load_val_s;
  logic                pt_load_s, pt_en_s;
  logic [RL_W-1:0]     rl_load_val_s;
  logic                rl_load_s, rl_en_s;

  piece_phase_fsm_ground_detect #(.N_CELLS(N_CELLS), .COORD_W(COORD_W)) u_ground (
    .ftr_rows(ftr_rows), .ftr_cols(ftr_cols), .ghost_rows(ghost_rows), .ghost_cols(ghost_cols),
    .grounded(grounded_s), .max_row(max_row_s)
  );

  piece_phase_fsm_counter #(.W(LT_W), .RST_VAL(LT_FULL)) u_lock_timer (
    .clk(clk), .rst_l(rst_l), .load(lt_load_s), .load_val(LT_FULL),
    .en(lt_en_s), .up(1'b0), .count(lock_timer_s)
  );

  piece_phase_fsm_counter #(.W(PT_W), .RST_VAL('0)) u_phase_timer (
    .clk(clk), .rst_l(rst_l), .load(pt_load_s), .load_val(pt_load_val_s),
    .en(pt_en_s), .up(1'b0), .count(phase_timer_s)
  );

  // Remaining move-resets are tracked directly, counting down per reload.
  piece_phase_fsm_counter #(.W(RL_W), .RST_VAL(RL_FULL)) u_resets_left (
    .clk(clk), .rst_l(rst_l), .load(rl_load_s), .load_val(rl_load_val_s),
    .en(rl_en_s), .up(1'b0), .count(resets_left)
  );

  // Next-state and timer control
  always_comb begin
    state_nxt_s   = state_r;
    lt_load_s     = 1'b0;
    lt_en_s       = 1'b0;
    pt_load_s     = 1'b0;
    pt_load_val_s = '0;
    pt_en_s       = 1'b0;
    rl_load_s     = 1'b0;
    rl_load_val_s = RL_FULL;
    rl_en_s       = 1'b0;
    deep_load_s   = 1'b0;
    step_s        = (STEP_RESET != 0) && (max_row_s > deepest_row_r);
    reload_ok_s   = step_s ? (MAX_LOCK_RESETS > 0) : (resets_left != '0);
    lock_now_s    = hard_drop || (grounded_s && (lock_timer_s == '0));
    reload_s      = grounded_s && user_input && reload_ok_s && !lock_now_s;
    case (state_r)
      PH_IDLE, PH_GAME_OVER: begin
        if (game_start) state_nxt_s = PH_SPAWN;
        else            state_nxt_s = state_r;
      end
      PH_SPAWN: begin
        lt_load_s   = 1'b1;
        rl_load_s   = 1'b1;
        deep_load_s = 1'b1;
        if (spawn_blocked) state_nxt_s = PH_GAME_OVER;
        else               state_nxt_s = PH_FALLING;
      end
      PH_FALLING: begin
        // A new depth refills the budget; a same-cycle reload spends one of it.
        deep_load_s   = step_s;
        rl_load_s     = step_s;
        rl_load_val_s = reload_s ? RL_AFTER : RL_FULL;
        rl_en_s       = reload_s && !step_s;
        lt_load_s     = reload_s;
        lt_en_s       = grounded_s && !reload_s && !lock_now_s;
        if (lock_now_s) state_nxt_s = PH_LOCK;
        else            state_nxt_s = PH_FALLING;
      end
      PH_LOCK: begin
        if (lines_cleared != 3'd0) begin
          state_nxt_s   = PH_CLEAR;
          pt_load_s     = 1'b1;
          pt_load_val_s = PT_CLEAR;
        end else if (ARE_DELAY > 0) begin
          state_nxt_s   = PH_ENTRY;
          pt_load_s     = 1'b1;
          pt_load_val_s = PT_ARE;
        end else begin
          state_nxt_s   = PH_SPAWN;
        end
      end
      PH_CLEAR: begin
        if (phase_timer_s != '0) begin
          pt_en_s = 1'b1;
        end else if (ARE_DELAY > 0) begin
          state_nxt_s   = PH_ENTRY;
          pt_load_s     = 1'b1;
          pt_load_val_s = PT_ARE;
        end else begin
          state_nxt_s   = PH_SPAWN;
        end
      end
      PH_ENTRY: begin
        if (phase_timer_s != '0) pt_en_s = 1'b1;
        else                     state_nxt_s = PH_SPAWN;
      end
      default: state_nxt_s = PH_IDLE;
    endcase
    // game_end freezes every timer and wins over all other transitions.
    if (game_end) begin
      state_nxt_s = PH_IDLE;
      lt_load_s   = 1'b0;
      lt_en_s     = 1'b0;
      pt_load_s   = 1'b0;
      pt_en_s     = 1'b0;
      rl_load_s   = 1'b0;
      rl_en_s     = 1'b0;
      deep_load_s = 1'b0;
    end else begin
      state_nxt_s = state_nxt_s;
    end
  end

  // State, deepest row and Moore outputs registered from the next state
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_r       <= PH_IDLE;
      deepest_row_r <= '0;
      new_tetromino <= 1'b0;
      piece_active  <= 1'b0;
      piece_locked  <= 1'b0;
      clear_busy    <= 1'b0;
      game_over     <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      deepest_row_r <= deep_load_s ? max_row_s : deepest_row_r;
      new_tetromino <= (state_nxt_s == PH_SPAWN);
      piece_active  <= (state_nxt_s == PH_FALLING);
      piece_locked  <= (state_nxt_s == PH_LOCK);
      clear_busy    <= (state_nxt_s == PH_CLEAR);
      game_over     <= (state_nxt_s == PH_GAME_OVER);
    end
  end

endmodule

// File: tb/tb_piece_phase_fsm.sv
// Table-driven bench for piece_phase_fsm with an expected-output queue.
module tb_piece_phase_fsm;

  localparam int NC = 4;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic rst_l, game_start, game_end, user_input, hard_drop, spawn_blocked;
  logic [2:0] lines_cleared;
  logic [NC-1:0][CW-1:0] ftr_rows, ftr_cols, ghost_rows, ghost_cols;
  logic new_tetromino, piece_active, piece_locked, clear_busy, game_over;
  logic [1:0] resets_left;

  typedef struct packed {
    logic nt, pa, pl, cb, go;
    logic [1:0] rl;
  } outs_t;

  typedef struct {
    logic gs, ge, ui, hd, sb;
    logic [2:0] lc;
    int fr, gr, reps;
    outs_t exp;
  } vec_t;

  vec_t  vecs[$];
  outs_t exp_q[$];
  int    checks = 0;
  int    failures = 0;

  piece_phase_fsm #(
    .N_CELLS(NC), .COORD_W(CW), .LOCK_DELAY(8), .MAX_LOCK_RESETS(3),
    .STEP_RESET(1), .CLEAR_DELAY(4), .ARE_DELAY(2)
  ) dut (
    .clk(clk), .rst_l(rst_l), .game_start(game_start), .game_end(game_end),
    .user_input(user_input), .hard_drop(hard_drop), .spawn_blocked(spawn_blocked),
    .lines_cleared(lines_cleared), .ftr_rows(ftr_rows), .ftr_cols(ftr_cols),
    .ghost_rows(ghost_rows), .ghost_cols(ghost_cols),
    .new_tetromino(new_tetromino), .piece_active(piece_active),
    .piece_locked(piece_locked), .clear_busy(clear_busy),
    .game_over(game_over), .resets_left(resets_left)
  );

  always #5 clk = ~clk;

  function automatic outs_t o(input logic nt, pa, pl, cb, go, input int rl);
    outs_t r;
    r = {nt, pa, pl, cb, go, 2'(rl)};
    return r;
  endfunction

  function automatic vec_t mk(input logic gs, ge, ui, hd, sb, input int lc, fr, gr, reps,
                              input outs_t exp);
    vec_t v;
    v.gs = gs; v.ge = ge; v.ui = ui; v.hd = hd; v.sb = sb;
    v.lc = 3'(lc); v.fr = fr; v.gr = gr; v.reps = reps; v.exp = exp;
    return v;
  endfunction

  // Horizontal four-cell piece on row fr, ghost on row gr, same columns.
  task automatic set_piece(input int fr, input int gr);
    for (int c = 0; c < NC; c++) begin
      ftr_rows[c]   = CW'(fr);
      ftr_cols[c]   = CW'(c);
      ghost_rows[c] = CW'(gr);
      ghost_cols[c] = CW'(c);
    end
  endtask

  task automatic check(input string name, input outs_t exp);
    outs_t got;
    got = {new_tetromino, piece_active, piece_locked, clear_busy, game_over, resets_left};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got nt=%b pa=%b pl=%b cb=%b go=%b rl=%0d, required nt=%b pa=%b pl=%b cb=%b go=%b rl=%0d",
               name, got.nt, got.pa, got.pl, got.cb, got.go, got.rl,
               exp.nt, exp.pa, exp.pl, exp.cb, exp.go, exp.rl);
    end
  endtask

  task automatic step(input string name, input vec_t v);
    @(negedge clk);
    game_start = v.gs; game_end = v.ge; user_input = v.ui;
    hard_drop = v.hd; spawn_blocked = v.sb; lines_cleared = v.lc;
    set_piece(v.fr, v.gr);
    exp_q.push_back(v.exp);
    @(posedge clk);
    #1;
    check(name, exp_q.pop_front());
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_l = 1'b0; game_start = 1'b0; game_end = 1'b0; user_input = 1'b0;
    hard_drop = 1'b0; spawn_blocked = 1'b0; lines_cleared = 3'd0;
    set_piece(2, 2);
    repeat (2) @(posedge clk);
    #1;
    check("reset", o(0, 0, 0, 0, 0, 3));
    @(negedge clk);
    rst_l = 1'b1;

    //             gs ge ui hd sb lc fr gr reps    nt pa pl cb go rl
    // Grounded from the first falling cycle, no input: 9 falling cycles, then ARE.
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 2, 2, 1, o(1, 0, 0, 0, 0, 3)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2, 2, 1, o(0, 1, 0, 0, 0, 3)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 7, 2, 2, 8, o(0, 1, 0, 0, 0, 3)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2, 2, 1, o(0, 0, 1, 0, 0, 3)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2, 2, 2, o(0, 0, 0, 0, 0, 3)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2, 2, 1, o(1, 0, 0, 0, 0, 3)));
    // Input every third grounded cycle spends the budget; fourth input is inert.
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2, 2, 3, o(0, 1, 0, 0, 0, 3)));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 2, 2, 1, o(0, 1, 0, 0, 0, 2)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2, 2, 2, o(0, 1, 0, 0, 0, 2)));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 2, 2, 1, o(0, 1, 0, 0, 0, 1)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2, 2, 2, o(0, 1, 0, 0, 0, 1)));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 2, 2, 1, o(0, 1, 0, 0, 0, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2, 2, 2, o(0, 1, 0, 0, 0, 0)));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 2, 2, 1, o(0, 1, 0, 0, 0, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2, 2, 5, o(0, 1, 0, 0, 0, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2, 2, 1, o(0, 0, 1, 0, 0, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2, 2, 2, o(0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2, 2, 1, o(1, 0, 0, 0, 0, 0)));
    // Exhaust, then new depth refills; same-cycle reload at a new depth costs one.
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2, 2, 1, o(0, 1, 0, 0, 0, 3)));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 2, 2, 1, o(0, 1, 0, 0, 0, 2)));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 2, 2, 1, o(0, 1, 0, 0, 0, 1)));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 2, 2, 1, o(0, 1, 0, 0, 0, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 4, 6, 1, o(0, 1, 0, 0, 0, 3)));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 6, 6, 1, o(0, 1, 0, 0, 0, 2)));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 6, 6, 1, o(0, 1, 0, 0, 0, 1)));
    // Airborne hard drop, two lines: CLEAR for 4 cycles, ENTRY for 2, then spawn.
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 6, 9, 1, o(0, 0, 1, 0, 0, 1)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 2, 6, 9, 1, o(0, 0, 0, 1, 0, 1)));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 6, 6, 3, o(0, 0, 0, 1, 0, 1)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 6, 6, 2, o(0, 0, 0, 0, 0, 1)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 6, 6, 1, o(1, 0, 0, 0, 0, 1)));
    // Blocked spawn tops out; restart, then game_end mid-CLEAR beats game_start.
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 2, 2, 1, o(0, 0, 0, 0, 1, 3)));
    vecs.push_back(mk(0, 0, 1, 1, 0, 3, 2, 2, 3, o(0, 0, 0, 0, 1, 3)));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 2, 2, 1, o(1, 0, 0, 0, 0, 3)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2, 2, 1, o(0, 1, 0, 0, 0, 3)));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 2, 2, 1, o(0, 0, 1, 0, 0, 3)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 2, 2, 2, o(0, 0, 0, 1, 0, 3)));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 2, 2, 2, o(0, 0, 0, 0, 0, 3)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2, 2, 2, o(0, 0, 0, 0, 0, 3)));

    foreach (vecs[i]) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        step($sformatf("vec%0d_rep%0d", i, r), vecs[i]);
      end
    end

    // Asynchronous reset in the middle of ENTRY, with one reset already spent.
    step("f_start", mk(1, 0, 0, 0, 0, 0, 2, 2, 1, o(1, 0, 0, 0, 0, 3)));
    step("f_spawn", mk(0, 0, 0, 0, 0, 0, 2, 2, 1, o(0, 1, 0, 0, 0, 3)));
    step("f_move",  mk(0, 0, 1, 0, 0, 0, 2, 2, 1, o(0, 1, 0, 0, 0, 2)));
    step("f_drop",  mk(0, 0, 0, 1, 0, 0, 2, 2, 1, o(0, 0, 1, 0, 0, 2)));
    step("f_entry", mk(0, 0, 0, 0, 0, 0, 2, 2, 1, o(0, 0, 0, 0, 0, 2)));
    @(negedge clk);
    rst_l = 1'b0;
    #1;
    check("rst_async", o(0, 0, 0, 0, 0, 3));
    @(posedge clk);
    #1;
    check("rst_hold", o(0, 0, 0, 0, 0, 3));
    @(negedge clk);
    rst_l = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step($sformatf("post_rst%0d", k), mk(0, 0, 0, 0, 0, 0, 2, 2, 1, o(0, 0, 0, 0, 0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
